// File: rtl/handshake_constant_seq.sv
// handshake_constant_seq
//   Elastic constant source. Every accepted control token loads the next entry
//   of CONST_TABLE into a registered output, cycling round-robin from entry 0.
//   Configuration macro: HANDSHAKE_CONST_SEQ_SKID_EN
//     undefined: one output slot, ctrl_ready = !outs_valid || outs_ready
//     defined  : main + skid slots, ctrl_ready driven only by registered state
module handshake_constant_seq #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CONSTS = 4,
  parameter logic [DATA_WIDTH*NUM_CONSTS-1:0] CONST_TABLE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ctrl_valid,
  output logic                  ctrl_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic                  outs_valid,
  input  logic                  outs_ready
);

  localparam int IDX_W = (NUM_CONSTS > 1) ? $clog2(NUM_CONSTS) : 1;

  if (NUM_CONSTS < 1 || NUM_CONSTS > 256) begin : g_bad_depth
    $error("handshake_constant_seq: NUM_CONSTS must be in 1..256");
  end

  function automatic logic [DATA_WIDTH-1:0] table_entry(input logic [IDX_W-1:0] i);
    return CONST_TABLE[32'(i)*DATA_WIDTH +: DATA_WIDTH];
  endfunction

  // Wraps at NUM_CONSTS-1 so non-power-of-two depths never index past the table.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    if (i == IDX_W'(NUM_CONSTS - 1)) begin
      return '0;
    end
    return i + IDX_W'(1);
  endfunction

  logic [IDX_W-1:0]      idx_p0;
  logic [DATA_WIDTH-1:0] entry_p0;
  logic                  accept;
  logic [DATA_WIDTH-1:0] main_data_p1;
  logic                  vld_p1;

  assign entry_p0 = table_entry(idx_p0);
  assign accept   = ctrl_valid && ctrl_ready;

  // ---- stage 0: table index, advanced only when a token is accepted ----
  // Round-robin index update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_p0 <= '0;
    end else if (accept) begin
      idx_p0 <= next_idx(idx_p0);
    end
  end

  // ---- stage 1: output storage ----
`ifdef HANDSHAKE_CONST_SEQ_SKID_EN
  logic [DATA_WIDTH-1:0] skid_data_p1;
  logic                  skid_vld_p1;
  logic                  transfer;

  assign transfer   = vld_p1 && outs_ready;
  // Ready depends only on a flop, which cuts the valid/ready path to the consumer.
  assign ctrl_ready = !skid_vld_p1;

  // Main/skid slot occupancy and main data; skid drains into main on transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1       <= 1'b0;
      main_data_p1 <= '0;
      skid_vld_p1  <= 1'b0;
    end else if (skid_vld_p1) begin
      // No accept possible here: ctrl_ready is low while skid is occupied.
      if (transfer) begin
        main_data_p1 <= skid_data_p1;
        skid_vld_p1  <= 1'b0;
      end
    end else if (accept) begin
      if (!vld_p1 || outs_ready) begin
        main_data_p1 <= entry_p0;
        vld_p1       <= 1'b1;
      end else begin
        skid_vld_p1  <= 1'b1;
      end
    end else if (transfer) begin
      vld_p1 <= 1'b0;
    end
  end

  // Skid data captured when an accept arrives while main is stalled; not reset.
  always_ff @(posedge clk) begin
    if (!skid_vld_p1 && accept && vld_p1 && !outs_ready) begin
      skid_data_p1 <= entry_p0;
    end
  end
`else
  assign ctrl_ready = !vld_p1 || outs_ready;

  // Single slot: reload on accept (even during a transfer), empty on bare transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1       <= 1'b0;
      main_data_p1 <= '0;
    end else if (accept) begin
      main_data_p1 <= entry_p0;
      vld_p1       <= 1'b1;
    end else if (outs_ready) begin
      vld_p1 <= 1'b0;
    end
  end
`endif

  assign outs       = main_data_p1;
  assign outs_valid = vld_p1;

endmodule

// File: tb/tb_handshake_constant_seq.sv
// Directed and soak bench for handshake_constant_seq (both macro builds).
module tb_handshake_constant_seq;

  localparam int DW = 15;
  localparam logic [DW*3-1:0] TABLE3 = {15'h7FFF, 15'h0001, 15'h2EEE};
`ifdef HANDSHAKE_CONST_SEQ_SKID_EN
  localparam logic SKID = 1'b1;
`else
  localparam logic SKID = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          ctrl_valid;
  logic          ctrl_ready;
  logic [DW-1:0] outs;
  logic          outs_valid;
  logic          outs_ready;

  logic          one_ctrl_valid;
  logic          one_ctrl_ready;
  logic [DW-1:0] one_outs;
  logic          one_outs_valid;
  logic          one_outs_ready;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] tbl [3];

  always #5 clk = ~clk;

  handshake_constant_seq #(
    .DATA_WIDTH (DW),
    .NUM_CONSTS (3),
    .CONST_TABLE(TABLE3)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .ctrl_valid(ctrl_valid),
    .ctrl_ready(ctrl_ready),
    .outs      (outs),
    .outs_valid(outs_valid),
    .outs_ready(outs_ready)
  );

  handshake_constant_seq #(
    .DATA_WIDTH (DW),
    .NUM_CONSTS (1),
    .CONST_TABLE(15'h1234)
  ) u_one (
    .clk       (clk),
    .rst       (rst),
    .ctrl_valid(one_ctrl_valid),
    .ctrl_ready(one_ctrl_ready),
    .outs      (one_outs),
    .outs_valid(one_outs_valid),
    .outs_ready(one_outs_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int            exp_idx;
    int            acc;
    int            xfr;
    logic          stall_prev;
    logic [DW-1:0] prev_outs;
    logic          cr_a;
    logic          cr_b;

    tbl[0] = 15'h2EEE;
    tbl[1] = 15'h0001;
    tbl[2] = 15'h7FFF;

    rst            = 1'b1;
    ctrl_valid     = 1'b0;
    outs_ready     = 1'b0;
    one_ctrl_valid = 1'b0;
    one_outs_ready = 1'b0;

    // Reset state
    tick();
    tick();
    #1;
    check("rst_valid", outs_valid, 0);
    check("rst_outs", outs, 0);
    check("rst_ready", ctrl_ready, 1);
    check("rst_one_outs", one_outs, 0);
    tick();
    rst = 1'b0;
    #1;
    check("post_rst_ready", ctrl_ready, 1);

    // Streaming with wrap: 7 tokens
    ctrl_valid = 1'b1;
    outs_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      tick();
      #1;
      check("stream_valid", outs_valid, 1);
      check("stream_outs", outs, tbl[k % 3]);
    end
    ctrl_valid = 1'b0;
    tick();
    #1;
    check("idle_valid", outs_valid, 0);
    check("idle_hold", outs, 15'h2EEE);

    // Reset mid-stream (asynchronous), then first token yields entry 0
    ctrl_valid = 1'b1;
    tick();
    #1;
    check("pre_rst_outs", outs, 15'h0001);
    rst = 1'b1;
    #1;
    check("async_rst_valid", outs_valid, 0);
    check("async_rst_outs", outs, 0);
    check("async_rst_ready", ctrl_ready, 1);
    tick();
    tick();
    rst = 1'b0;
    tick();
    #1;
    check("first_after_rst_valid", outs_valid, 1);
    check("first_after_rst_outs", outs, 15'h2EEE);

    // Backpressure for 5 edges with ctrl_valid held high
    outs_ready = 1'b0;
    #1;
    check("bp_ready_first", ctrl_ready, SKID ? 1 : 0);
    tick();
    for (int c = 1; c < 5; c++) begin
      #1;
      check("bp_outs", outs, 15'h2EEE);
      check("bp_valid", outs_valid, 1);
      check("bp_ready", ctrl_ready, 0);
      tick();
    end
    outs_ready = 1'b1;
    #1;
    tick();
    #1;
    check("release_outs0", outs, 15'h0001);
    check("release_valid0", outs_valid, 1);
    check("release_ready", ctrl_ready, 1);
    tick();
    #1;
    check("release_outs1", outs, 15'h7FFF);
    check("release_valid1", outs_valid, 1);
    ctrl_valid = 1'b0;
    tick();
    #1;
    check("release_drain_valid", outs_valid, 0);
    check("release_drain_hold", outs, 15'h7FFF);

    // Sparse tokens: one pulse every third cycle
    for (int k = 0; k < 6; k++) begin
      ctrl_valid = 1'b1;
      tick();
      ctrl_valid = 1'b0;
      #1;
      check("sparse_valid", outs_valid, 1);
      check("sparse_outs", outs, tbl[k % 3]);
      tick();
      #1;
      check("sparse_gap_valid", outs_valid, 0);
      check("sparse_gap_hold", outs, tbl[k % 3]);
      tick();
    end

    // Degenerate depth: every token yields the single entry
    one_ctrl_valid = 1'b1;
    one_outs_ready = 1'b1;
    #1;
    check("one_ready", one_ctrl_ready, 1);
    for (int k = 0; k < 4; k++) begin
      tick();
      #1;
      check("one_valid", one_outs_valid, 1);
      check("one_outs", one_outs, 15'h1234);
    end
    one_ctrl_valid = 1'b0;

    // Random handshake soak with scoreboard, then drain
    exp_idx    = 0;
    acc        = 0;
    xfr        = 0;
    stall_prev = 1'b0;
    prev_outs  = '0;
    for (int cyc = 0; cyc < 10004; cyc++) begin
      tick();
      if (stall_prev) begin
        check("stall_valid", outs_valid, 1);
        check("stall_outs", outs, prev_outs);
      end
      ctrl_valid = (cyc < 10000) ? 1'($urandom_range(0, 1)) : 1'b0;
      outs_ready = 1'b0;
      #1;
      cr_a = ctrl_ready;
      outs_ready = 1'b1;
      #1;
      cr_b = ctrl_ready;
      check("ready_path", cr_a, SKID ? cr_b : !outs_valid);
      outs_ready = (cyc < 10000) ? ($urandom_range(0, 3) != 0) : 1'b1;
      #1;
      if (ctrl_valid && ctrl_ready) acc++;
      if (outs_valid && outs_ready) begin
        check("soak_outs", outs, tbl[exp_idx]);
        exp_idx = (exp_idx + 1) % 3;
        xfr++;
      end
      stall_prev = outs_valid && !outs_ready;
      prev_outs  = outs;
    end
    check("soak_no_loss", xfr, acc);
    check("soak_drained", outs_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
